// File: rtl/wbq_pkg.sv
// wbq_pkg: shared types and constants for the writeback write queue.
//   ADDR_W / DATA_W : register address / data widths of the 32x32 register file
//   wbq_entry_t     : one queued register write {addr, data}
//   DEPTH_MIN/MAX   : legal queue depth range (power of two only)
package wbq_pkg;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbq_entry_t;

  function automatic bit wbq_depth_ok(input int d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX) && ((d & (d - 1)) == 0);
  endfunction
endpackage

// File: rtl/wbq_fwd_match.sv
// wbq_fwd_match: youngest-first forwarding search over the queue storage.
//   entries : queue storage, indexed by physical slot
//   valid   : occupied-slot mask
//   tail    : write pointer (slot the next push lands in)
//   lk_addr : register being looked up
//   hit     : some occupied slot holds lk_addr (never for r0)
//   data    : data of the youngest matching slot
module wbq_fwd_match
  import wbq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wbq_entry_t [DEPTH-1:0]  entries,
  input  logic [DEPTH-1:0]        valid,
  input  logic [PTR_W-1:0]        tail,
  input  logic [ADDR_W-1:0]       lk_addr,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);
  logic [PTR_W-1:0] idx;

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); a later
  // match overrides an earlier one, so the youngest entry wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if (valid[idx] && (lk_addr != '0) && (entries[idx].addr == lk_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer in front of the register file
// write port, with optional forwarding lookups into pending entries.
//   CLK/RST_N              : clock, async active-low reset
//   InValid/InReady        : request handshake (InAddr, InData)
//   DrainEn                : permit one register file write this cycle
//   RegWriteW/A3/WD        : register file write port, driven from the head
//   LkAddr1/2 -> LkHit/Data: forwarding lookups (youngest pending match)
//   Count                  : occupied entries
// Build option: define WBQ_FWD_EN to build the lookup logic; without it the
// lookup outputs are tied to zero and the lookup ports are ignored.
// DATA_W / ADDR_W must match the wbq_pkg widths used by the entry struct.
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = wbq_pkg::DATA_W,
  parameter int ADDR_W = wbq_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] InAddr,
  input  logic [DATA_W-1:0] InData,
  input  logic              DrainEn,
  output logic              RegWriteW,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] LkAddr1,
  input  logic [ADDR_W-1:0] LkAddr2,
  output logic              LkHit1,
  output logic              LkHit2,
  output logic [DATA_W-1:0] LkData1,
  output logic [DATA_W-1:0] LkData2,
  output logic [3:0]        Count
);
  localparam int PTR_W = $clog2(DEPTH);

  if (!wbq_depth_ok(DEPTH)) begin : g_depth_check
    $error("wb_write_queue: DEPTH must be a power of two in 2..8");
  end

  wbq_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [3:0]             count_q, count_d;
  logic                   push, pop, not_empty;

  // Ready depends only on occupancy: a full queue stalls even if it pops now.
  assign InReady   = (count_q < 4'(DEPTH));
  assign not_empty = (count_q != 4'd0);
  // r0 writes are accepted and dropped.
  assign push      = InValid && InReady && (InAddr != '0);
  assign pop       = DrainEn && not_empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: InAddr, data: InData};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write port comes straight from storage; gated to zero when empty.
  always_comb begin
    RegWriteW = pop;
    A3        = '0;
    WD        = '0;
    if (not_empty) begin
      A3 = mem_q[rd_ptr_q].addr;
      WD = mem_q[rd_ptr_q].data;
    end
  end

  assign Count = count_q;

`ifdef WBQ_FWD_EN
  logic [DEPTH-1:0] occ;

  // A slot is occupied when its distance from the head is below Count.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = (4'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q);
    end
  end

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (mem_q),
    .valid   (occ),
    .tail    (wr_ptr_q),
    .lk_addr (LkAddr1),
    .hit     (LkHit1),
    .data    (LkData1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (mem_q),
    .valid   (occ),
    .tail    (wr_ptr_q),
    .lk_addr (LkAddr2),
    .hit     (LkHit2),
    .data    (LkData2)
  );
`else
  logic unused_lk;
  assign unused_lk = ^{LkAddr1, LkAddr2};
  assign LkHit1    = 1'b0;
  assign LkHit2    = 1'b0;
  assign LkData1   = '0;
  assign LkData2   = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue. The stimulus side records each
// accepted non-r0 request in an expected-writes queue; a negedge monitor
// compares the write port, occupancy, ready and lookups against that queue
// and retires the head whenever the DUT issues a write.
module tb_wb_write_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        InValid, InReady, DrainEn, RegWriteW;
  logic [4:0]  InAddr, A3, LkAddr1, LkAddr2;
  logic [31:0] InData, WD, LkData1, LkData2;
  logic        LkHit1, LkHit2;
  logic [3:0]  Count;

  wr_t sb[$];
  bit  exp_ready = 1'b1;
  int  n_vec = 0;
  int  n_err = 0;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .InValid(InValid), .InReady(InReady), .InAddr(InAddr), .InData(InData),
    .DrainEn(DrainEn), .RegWriteW(RegWriteW), .A3(A3), .WD(WD),
    .LkAddr1(LkAddr1), .LkAddr2(LkAddr2),
    .LkHit1(LkHit1), .LkHit2(LkHit2), .LkData1(LkData1), .LkData2(LkData2),
    .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Pending writes in arrival order; the last match is the youngest.
  function automatic void ref_lk(input logic [4:0] a, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0)
      foreach (sb[i]) if (sb[i].addr == a) begin hit = 1'b1; d = sb[i].data; end
`ifndef WBQ_FWD_EN
    hit = 1'b0;
    d   = '0;
`endif
  endfunction

  // Monitor: observe the settled cycle, then retire the head if written.
  always @(negedge CLK) begin
    int   n;
    bit   h1, h2;
    logic [31:0] d1, d2;
    if (RST_N) begin
      n         = sb.size();
      exp_ready = (n < DEPTH);
      chk("count", 32'(Count), 32'(n));
      chk("in_ready", 32'(InReady), 32'(exp_ready));
      chk("reg_write", 32'(RegWriteW), 32'(DrainEn && n != 0));
      if (n == 0) begin
        chk("a3_idle", 32'(A3), 32'd0);
        chk("wd_idle", WD, 32'd0);
      end
      ref_lk(LkAddr1, h1, d1);
      ref_lk(LkAddr2, h2, d2);
      chk("lk_hit1", 32'(LkHit1), 32'(h1));
      chk("lk_hit2", 32'(LkHit2), 32'(h2));
      if (h1) chk("lk_data1", LkData1, d1);
      if (h2) chk("lk_data2", LkData2, d2);
      if (RegWriteW && n != 0) begin
        chk("a3", 32'(A3), 32'(sb[0].addr));
        chk("wd", WD, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus: drive, take the edge, record an accepted write.
  task automatic cyc(input bit v, input logic [4:0] a, input logic [31:0] d,
                     input bit dr, input logic [4:0] l1, input logic [4:0] l2,
                     output bit acc);
    InValid = v; InAddr = a; InData = d; DrainEn = dr; LkAddr1 = l1; LkAddr2 = l2;
    @(posedge CLK);
    acc = v && exp_ready;
    if (acc && a != 5'd0) sb.push_back('{addr: a, data: d});
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    bit acc;
    bit exp_fwd;
`ifdef WBQ_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    RST_N = 1'b0; InValid = 0; InAddr = 0; InData = 0; DrainEn = 0; LkAddr1 = 0; LkAddr2 = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_ready", 32'(InReady), 32'd1);
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_a3", 32'(A3), 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_lkhit1", 32'(LkHit1), 32'd0);
    RST_N = 1'b1;

    // Single push, written on the following edge.
    cyc(1, 5'd5, 32'hDEADBEEF, 1, 0, 0, acc);
    chk("single_we", 32'(RegWriteW), 32'd1);
    chk("single_a3", 32'(A3), 32'd5);
    chk("single_wd", WD, 32'hDEADBEEF);
    cyc(0, 0, 0, 1, 0, 0, acc);
    chk("single_count_after", 32'(Count), 32'd0);

    // Fill, hold a fifth request, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(1, 5'(i), 32'h100 + 32'(i), 0, 0, 0, acc);
    chk("full_count", 32'(Count), 32'd4);
    chk("full_ready", 32'(InReady), 32'd0);
    repeat (2) cyc(1, 5'd6, 32'h66, 0, 0, 0, acc);
    acc = 0;
    for (int t = 0; t < 10 && !acc; t++) cyc(1, 5'd6, 32'h66, 1, 0, 0, acc);
    chk("held_req_accepted", 32'(acc), 32'd1);
    repeat (6) cyc(0, 0, 0, 1, 0, 0, acc);

    // Forwarding: youngest of two r7 writes wins, r0 never hits.
    cyc(1, 5'd7, 32'h11, 0, 0, 0, acc);
    cyc(1, 5'd7, 32'h22, 0, 0, 0, acc);
    InValid = 0; LkAddr1 = 5'd7; LkAddr2 = 5'd0;
    #1;
    chk("fwd_hit1", 32'(LkHit1), 32'(exp_fwd));
    chk("fwd_data1", LkData1, exp_fwd ? 32'h22 : 32'h0);
    chk("fwd_hit2_r0", 32'(LkHit2), 32'd0);
    repeat (3) cyc(0, 0, 0, 1, 5'd7, 5'd0, acc);

    // r0 request is consumed but never written.
    cyc(1, 5'd0, 32'h55, 1, 0, 0, acc);
    chk("r0_accepted", 32'(acc), 32'd1);
    chk("r0_count", 32'(Count), 32'd0);
    chk("r0_no_write", 32'(RegWriteW), 32'd0);

    // Streaming: one in, one out every cycle.
    for (int i = 0; i < 20; i++) cyc(1, 5'(1 + i % 31), 32'hA000 + 32'(i), 1, 5'(1 + i % 31), 0, acc);
    chk("stream_count", 32'(Count), 32'd1);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, acc);

    // Asynchronous reset with three writes pending.
    for (int i = 0; i < 3; i++) cyc(1, 5'(9 + i), 32'hB0 + 32'(i), 0, 0, 0, acc);
    RST_N = 1'b0;
    DrainEn = 1'b1;
    #1;
    chk("midrst_count", 32'(Count), 32'd0);
    chk("midrst_regwrite", 32'(RegWriteW), 32'd0);
    sb.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (3) cyc(0, 0, 0, 1, 0, 0, acc);

    // Randomized traffic with address collisions.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
    repeat (8) cyc(0, 0, 0, 1, 0, 0, acc);
    chk("final_drained", 32'(Count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
